// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the fetch-PC redirect unit.
// The TRAP state exists only when PC_MISALIGN_CHECK_EN is defined.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    REDIRECT
`ifdef PC_MISALIGN_CHECK_EN
    ,
    TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET
  } pc_sel_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Branch comparator selects driven by decode into the EX-stage ALU.
  typedef enum logic [5:0] {
    ALU_BEQ  = 6'b001010,
    ALU_BNE  = 6'b001100,
    ALU_BLT  = 6'b001110,
    ALU_BGE  = 6'b010000,
    ALU_BLTU = 6'b010010,
    ALU_BGEU = 6'b010100
  } branch_alu_sel_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_next_mux.sv
// Next fetch-PC selector: hold, sequential increment, or redirect target.
module pc_next_mux
  import pc_redirect_unit_pkg::*;
(
  input  logic [31:0] cur_pc,
  input  logic [31:0] target,
  input  pc_sel_t     sel,
  output logic [31:0] next_pc
);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_pc = cur_pc;
    unique case (sel)
      PC_INC:    next_pc = cur_pc + PC_INCR;
      PC_TARGET: next_pc = target;
      default:   next_pc = cur_pc;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-PC register and redirect FSM (INIT/RUN/REDIRECT, plus TRAP when
// PC_MISALIGN_CHECK_EN is defined). All outputs come straight from flops.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
);

  state_t      state, state_next;
  pc_sel_t     pc_sel;
  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        flush_next;

`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned;
  logic trap_enter;

  assign redirect_target = ex_target;
  assign misaligned      = !is_word_aligned(ex_target);
`else
  // Without the check, low target bits are simply dropped.
  assign redirect_target = ex_target & ~32'h3;
`endif

  pc_next_mux u_pc_next_mux (
    .cur_pc  (if_pc),
    .target  (redirect_target),
    .sel     (pc_sel),
    .next_pc (pc_next)
  );

  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    flush_next = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    trap_enter = 1'b0;
`endif
    unique case (state)
      INIT: state_next = RUN;
      RUN: begin
        // A taken branch wins over a stall: the stalled instruction is squashed anyway.
        if (ex_valid && ex_taken) begin
          flush_next = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
          if (misaligned) begin
            trap_enter = 1'b1;
            state_next = TRAP;
          end else begin
            pc_sel     = PC_TARGET;
            state_next = REDIRECT;
          end
`else
          pc_sel     = PC_TARGET;
          state_next = REDIRECT;
`endif
        end else begin
          pc_sel = stall ? PC_HOLD : PC_INC;
        end
      end
      REDIRECT: begin
        // The EX instruction here is the wrong-path one being flushed; ignore it.
        pc_sel     = stall ? PC_HOLD : PC_INC;
        state_next = RUN;
      end
`ifdef PC_MISALIGN_CHECK_EN
      TRAP: state_next = TRAP;
`endif
      default: state_next = INIT;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      if_pc      <= RESET_PC;
      if_valid   <= 1'b0;
      flush_ifid <= 1'b0;
      flush_idex <= 1'b0;
    end else begin
      state      <= state_next;
      if_pc      <= pc_next;
      if_valid   <= (state_next == RUN) || (state_next == REDIRECT);
      flush_ifid <= flush_next;
      flush_idex <= flush_next;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else if (trap_enter) begin
      misalign_trap <= 1'b1;
      misalign_addr <= ex_target;
    end
  end
`else
  assign misalign_trap = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_pc_redirect_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        misalign_trap;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_redirect_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " if_pc"},         if_pc,         TB_RESET_PC);
    check({tag, " if_valid"},      32'(if_valid),      32'd0);
    check({tag, " flush_ifid"},    32'(flush_ifid),    32'd0);
    check({tag, " flush_idex"},    32'(flush_idex),    32'd0);
    check({tag, " misalign_trap"}, 32'(misalign_trap), 32'd0);
    check({tag, " misalign_addr"}, misalign_addr,      32'd0);
  endtask

  task automatic drive(input logic s, input logic v, input logic t, input logic [31:0] tgt);
    stall     = s;
    ex_valid  = v;
    ex_taken  = t;
    ex_target = tgt;
  endtask

  // Apply inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic v, input logic t, input logic [31:0] tgt);
    drive(s, v, t, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asserts reset between clock edges (called just after a sample point).
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_addr;
  bit          m_valid, m_flush, m_trap, m_started, m_squash;

  function automatic void model_reset();
    m_pc      = TB_RESET_PC;
    m_addr    = 32'h0;
    m_valid   = 1'b0;
    m_flush   = 1'b0;
    m_trap    = 1'b0;
    m_started = 1'b0;
    m_squash  = 1'b0;
  endfunction

  // Outcome of one clock edge given the inputs presented before it.
  function automatic void model_step(input bit s, input bit v, input bit t, input logic [31:0] tgt);
    m_flush = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
      m_valid   = 1'b1;
    end else if (m_trap) begin
      // frozen until reset
    end else if (v && t && !m_squash) begin
      m_flush = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
      if (tgt % 4 != 0) begin
        m_trap   = 1'b1;
        m_valid  = 1'b0;
        m_addr   = tgt;
        m_squash = 1'b0;
        return;
      end
`endif
      m_pc     = tgt - (tgt % 4);
      m_squash = 1'b1;
    end else begin
      if (!s) m_pc = m_pc + 32'd4;
      m_squash = 1'b0;
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        s;
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_000C, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0104, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0300, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0300, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0304, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};

    // Reset release: one INIT cycle with if_valid low, then 0x0, 0x4, 0x8.
    apply_reset("por");
    check("init if_valid", 32'(if_valid), 32'd0);
    cyc(0, 0, 0, 0); check("boot pc0", if_pc, 32'h0); check("boot valid0", 32'(if_valid), 32'd1);
    cyc(0, 0, 0, 0); check("boot pc1", if_pc, 32'h4);
    cyc(0, 0, 0, 0); check("boot pc2", if_pc, 32'h8);

    // Table from a fresh reset.
    apply_reset("table");
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].s, vecs[i].v, vecs[i].t, vecs[i].tgt);
      check($sformatf("vec%0d if_pc", i),      if_pc,            vecs[i].exp_pc);
      check($sformatf("vec%0d if_valid", i),   32'(if_valid),    32'd1);
      check($sformatf("vec%0d flush_ifid", i), 32'(flush_ifid),  32'(vecs[i].exp_flush));
      check($sformatf("vec%0d flush_idex", i), 32'(flush_idex),  32'(vecs[i].exp_flush));
    end

    // Redirect at 0x100 with stall: target taken, flushes for one cycle only.
    apply_reset("r030");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h100);
    cyc(1, 0, 0, 0);
    check("r030 setup pc", if_pc, 32'h100);
    cyc(1, 1, 1, 32'h200);
    check("r030 pc", if_pc, 32'h200);
    check("r030 flush_ifid", 32'(flush_ifid), 32'd1);
    check("r030 flush_idex", 32'(flush_idex), 32'd1);
    cyc(0, 0, 0, 0);
    check("r030 pc+1", if_pc, 32'h204);
    check("r030 flush_ifid drop", 32'(flush_ifid), 32'd0);
    check("r030 flush_idex drop", 32'(flush_idex), 32'd0);

    // Not-taken branch at 0x10.
    apply_reset("r031");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h10);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 32'h400);
    check("r031 pc", if_pc, 32'h14);
    check("r031 flush", 32'(flush_ifid | flush_idex), 32'd0);

    // Back-to-back taken branches: second ignored.
    apply_reset("r032");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h300);
    check("r032 pc0", if_pc, 32'h300);
    cyc(0, 1, 1, 32'h500);
    check("r032 pc1", if_pc, 32'h304);
    check("r032 no flush", 32'(flush_ifid), 32'd0);

    // Misaligned taken target.
    apply_reset("r033");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h202);
`ifdef PC_MISALIGN_CHECK_EN
    check("r033 trap", 32'(misalign_trap), 32'd1);
    check("r033 addr", misalign_addr, 32'h202);
    check("r033 valid", 32'(if_valid), 32'd0);
    check("r033 flush", 32'(flush_ifid & flush_idex), 32'd1);
    check("r033 pc held", if_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(k[0], 1, 1, 32'h100);
      check("r033 stuck valid", 32'(if_valid), 32'd0);
      check("r033 stuck trap", 32'(misalign_trap), 32'd1);
      check("r033 stuck pc", if_pc, 32'h0);
      check("r033 stuck flush", 32'(flush_ifid), 32'd0);
    end
    async_reset("r033 exit");
`else
    check("r033 pc", if_pc, 32'h200);
    check("r033 valid", 32'(if_valid), 32'd1);
    check("r033 trap", 32'(misalign_trap), 32'd0);
    check("r033 addr", misalign_addr, 32'h0);
`endif

    // Reset asserted between edges while in REDIRECT.
    apply_reset("r034 pre");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h300);
    check("r034 in redirect", 32'(flush_ifid), 32'd1);
    async_reset("r034");

    // Randomized run against the model, with occasional mid-cycle resets.
    apply_reset("rand");
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        rs, rv, rt;
      logic [31:0] rtgt;
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand rst");
        model_reset();
      end
      rs   = ($urandom_range(0, 3) == 0);
      rv   = ($urandom_range(0, 2) != 0);
      rt   = $urandom_range(0, 1) != 0;
      rtgt = $urandom & ~32'h3;
      if ($urandom_range(0, 63) == 0) rtgt[1:0] = 2'($urandom_range(1, 3));
      model_step(rs, rv, rt, rtgt);
      cyc(rs, rv, rt, rtgt);
      check("rand if_pc",         if_pc,              m_pc);
      check("rand if_valid",      32'(if_valid),      32'(m_valid));
      check("rand flush_ifid",    32'(flush_ifid),    32'(m_flush));
      check("rand flush_idex",    32'(flush_idex),    32'(m_flush));
      check("rand misalign_trap", 32'(misalign_trap), 32'(m_trap));
      check("rand misalign_addr", misalign_addr,      m_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hazard stall; holds fetch PC.
REQ-005 SHALL have port ex_valid  input  1  a branch/jump resolved in EX this cycle.
REQ-006 SHALL have port ex_taken  input  1  comparator outcome for the resolving branch.
REQ-007 SHALL have port ex_target  input  32  branch/jump target address.
REQ-008 SHALL have port if_pc  output  32  current fetch address.
REQ-009 SHALL have port if_valid  output  1  if_pc is a fetchable address.
REQ-010 SHALL have port flush_ifid  output  1  one-cycle kill of IF/ID register.
REQ-011 SHALL have port flush_idex  output  1  one-cycle kill of ID/EX register.
REQ-012 SHALL have port misalign_trap  output  1  sticky misaligned-target flag.
REQ-013 SHALL have port misalign_addr  output  32  offending target address.

Function
REQ-014 SHALL implement states INIT, RUN, REDIRECT, TRAP; all outputs registered.
REQ-015 INIT: entered on reset, if_valid=0, lasts exactly one cycle, then RUN.
REQ-016 RUN, no redirect: stall=0 -> if_pc <= if_pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); stall=1 -> if_pc held.
REQ-017 RUN, ex_valid=1 and ex_taken=0: treated as no redirect.
REQ-018 RUN, ex_valid=1 and ex_taken=1 with aligned target: next cycle if_pc=ex_target, flush_ifid=flush_idex=1 for exactly that cycle, state REDIRECT.
REQ-019 Redirect SHALL take priority over stall in the same cycle.
REQ-020 REDIRECT: lasts one cycle; ex_valid ignored (instruction in EX is being squashed); PC advances per stall; then RUN.
REQ-021 Back-to-back taken branches: second arriving in REDIRECT SHALL be ignored; one arriving in the following RUN cycle SHALL redirect normally.
REQ-022 if_valid SHALL be 1 in RUN and REDIRECT, 0 in INIT and TRAP.

Reset
REQ-023 rst_n low SHALL immediately force if_pc=RESET_PC, if_valid=0, flush_ifid=0, flush_idex=0, misalign_trap=0, misalign_addr=0, state INIT, regardless of clock, including mid-redirect or in TRAP.
REQ-024 TRAP SHALL be exited only by reset.

Configuration
REQ-025 Macro PC_MISALIGN_CHECK_EN defined: taken redirect with ex_target[1:0]!=0 SHALL go to TRAP, set misalign_trap=1, capture misalign_addr=ex_target, pulse both flushes once, hold if_pc.
REQ-026 Macro undefined: ex_target[1:0] SHALL be forced to 00 and redirect proceeds per REQ-018; misalign_trap and misalign_addr tied 0; TRAP state absent.

Structure
REQ-027 Shared package SHALL hold the state enumeration, PC increment constant (4) and the 6-bit branch aluSelect encodings (BEQ 001010, BNE 001100, BLT 001110, BGE 010000, BLTU 010010, BGEU 010100).
REQ-028 One sub-module, pc_next_mux, SHALL compute next PC (hold / +4 / target) combinationally; FSM and registers live in the top.

Verification
REQ-029 Reset release, stall=0, 4 cycles -> if_valid 0 for 1 cycle, then if_pc 0x0, 0x4, 0x8.
REQ-030 if_pc=0x100, ex_valid=1, ex_taken=1, ex_target=0x200, stall=1 -> next cycle if_pc=0x200, both flushes high one cycle only.
REQ-031 ex_valid=1, ex_taken=0, target=0x400 at if_pc=0x10 -> if_pc=0x14, no flush.
REQ-032 Taken to 0x300 then taken to 0x500 next cycle -> second ignored, if_pc 0x300, 0x304.
REQ-033 PC_MISALIGN_CHECK_EN, taken target 0x202 -> misalign_trap=1, misalign_addr=0x202, if_valid=0 until rst_n low; undefined -> if_pc=0x200.
REQ-034 rst_n asserted mid-REDIRECT, between clock edges -> all outputs at reset values immediately.
